uart_tx_sched: RTL

Transmit scheduler that shares one UART transmitter between two requesters. The first is an echo channel, which returns received bytes. The second is a periodic fixed-length message generator that reads its characters from an external ROM. It sits between the UART receiver/ROM and the UART transmitter. It owns the transmitter's `wrsig`/`dataout` strobe interface and paces bytes so that no frame is overrun.

---
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/uart_tx_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// Signal bundle between the transmit scheduler and its neighbours:
// UART receiver (rdsig/rxdata), message ROM (msg_addr/msg_data),
// UART transmitter (wrsig/dataout) and status flags.
// The master side is the scheduler; the slave side is the environment.
// Handshake: rdsig and wrsig are one-cycle strobes with no back-pressure;
// data (rxdata, dataout) is valid in the cycle its strobe is high, and
// dataout additionally holds its value until the next wrsig pulse.
interface uart_tx_sched_if;
   logic       rdsig;
   logic [7:0] rxdata;
   logic       msg_en;
   logic [4:0] msg_addr;
   logic [7:0] msg_data;
   logic       wrsig;
   logic [7:0] dataout;
   logic       fifo_full;
   logic       overflow;
   logic       busy;

   modport master (
      input  rdsig, rxdata, msg_en, msg_data,
      output msg_addr, wrsig, dataout, fifo_full, overflow, busy
   );

   modport slave (
      output rdsig, rxdata, msg_en, msg_data,
      input  msg_addr, wrsig, dataout, fifo_full, overflow, busy
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Transmit scheduler sharing one UART transmitter between an echo FIFO
// and a periodic ROM-driven message generator. Bytes are paced so that
// consecutive wrsig pulses are at least BYTE_CYCLES clocks apart, and
// arbitration is round-robin where one echo byte and one whole message
// each count as a single unit.
// dbg_state = {in_msg, state==GAP}, exposed for observation only.
module uart_tx_sched #(
   parameter int BYTE_CYCLES = 255,
   parameter int PERIOD      = 262144,
   parameter int FIFO_DEPTH  = 16,
   parameter int MSG_LEN     = 21
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_sched_if.master bus,
   output logic [1:0]      dbg_state
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int GW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_LAST   = GW'(BYTE_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
   localparam logic [4:0]    ADDR_LAST  = 5'(MSG_LEN - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   typedef enum logic {
      GR_ECHO = 1'b0,
      GR_MSG  = 1'b1
   } grant_t;

   // Echo FIFO storage and bookkeeping
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          fifo_full_q;
   logic          overflow_q;

   // Message timer
   logic [TW-1:0] timer;
   logic          msg_pending;

   // Scheduler state and registered outputs
   state_t        state;
   logic [GW-1:0] gap_cnt;
   logic          in_msg;
   grant_t        last_grant;
   logic          wrsig_q;
   logic [7:0]    dataout_q;
   logic [4:0]    msg_addr_q;
   logic          busy_q;

   // Decision-cycle signals
   logic          fifo_empty;
   logic          is_full;
   logic          push;
   logic          drop;
   logic          pop;
   logic          decide;
   logic          grant_char;
   logic          grant_msg;
   logic          grant_echo;
   logic          send_msg;
   logic [7:0]    head;

   // Arbitration: a decision happens in IDLE and in the last GAP cycle
   always_comb begin
      fifo_empty = (count == '0);
      is_full    = (count == FULL_COUNT);
      head       = mem[rd_ptr];
      push       = bus.rdsig && !is_full;
      drop       = bus.rdsig && is_full;
      decide     = (state == ST_IDLE) || (gap_cnt == GAP_LAST);
      // Mid-message characters go out unconditionally
      grant_char = decide && in_msg;
      // A new message wins when echo has had its turn or has nothing queued
      grant_msg  = decide && !in_msg && msg_pending &&
                   (fifo_empty || (last_grant == GR_ECHO));
      grant_echo = decide && !in_msg && !fifo_empty &&
                   !(msg_pending && (last_grant == GR_ECHO));
      send_msg   = grant_char || grant_msg;
      pop        = grant_echo;
   end

   // Next FIFO occupancy; simultaneous push and pop leave it unchanged
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // FIFO data array, written on every accepted receive byte
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.rxdata;
      end
   end

   // FIFO pointers, occupancy, full flag and drop indication
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         fifo_full_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count       <= count_next;
         fifo_full_q <= (count_next == FULL_COUNT);
         overflow_q  <= drop;
      end
   end

   // Message timer: a trigger every PERIOD clocks while enabled, no queueing
   always_ff @(posedge clk) begin
      if (!rst_n || !bus.msg_en) begin
         timer       <= '0;
         msg_pending <= 1'b0;
      end else if (timer == TIMER_LAST) begin
         timer       <= '0;
         msg_pending <= 1'b1;
      end else begin
         timer <= timer + TW'(1);
         if (grant_msg) begin
            msg_pending <= 1'b0;
         end
      end
   end

   // Scheduler FSM: emits strobes, paces the gap, sequences message characters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         gap_cnt    <= '0;
         in_msg     <= 1'b0;
         last_grant <= GR_ECHO;
         wrsig_q    <= 1'b0;
         dataout_q  <= 8'h00;
         msg_addr_q <= 5'd0;
         busy_q     <= 1'b0;
      end else begin
         wrsig_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               gap_cnt <= '0;
            end
            ST_GAP: begin
               if (!decide) begin
                  gap_cnt <= gap_cnt + GW'(1);
               end else begin
                  gap_cnt <= '0;
               end
            end
            default: begin
               gap_cnt <= '0;
            end
         endcase

         if (decide) begin
            if (send_msg || grant_echo) begin
               wrsig_q <= 1'b1;
               state   <= ST_GAP;
               busy_q  <= 1'b1;
            end else begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         end

         if (send_msg) begin
            dataout_q  <= bus.msg_data;
            last_grant <= GR_MSG;
            // The last character wraps the address and closes the message
            if (msg_addr_q == ADDR_LAST) begin
               msg_addr_q <= 5'd0;
               in_msg     <= 1'b0;
            end else begin
               msg_addr_q <= msg_addr_q + 5'd1;
               in_msg     <= 1'b1;
            end
         end else if (grant_echo) begin
            dataout_q  <= head;
            last_grant <= GR_ECHO;
         end
      end
   end

   assign bus.wrsig     = wrsig_q;
   assign bus.dataout   = dataout_q;
   assign bus.msg_addr  = msg_addr_q;
   assign bus.fifo_full = fifo_full_q;
   assign bus.overflow  = overflow_q;
   assign bus.busy      = busy_q;
   assign dbg_state     = {in_msg, (state == ST_GAP)};

endmodule
